// File: rtl/reg_wb_pkg.sv
// Shared types and widths for the register writeback scheduler.
package reg_wb_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned WB_NUM_SRC = 2;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Number of set bits in the busy scoreboard.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when both sources request.
module rr_arbiter2
  import reg_wb_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WB_NUM_SRC-1:0] req,
  output logic [WB_NUM_SRC-1:0] grant
);

  wb_src_e rr_ptr;

  // On conflict the source that did not win last time is granted.
  always_comb begin
    grant = '0;
    if (&req) begin
      if (rr_ptr == WB_SRC_ALU) grant = 2'b10;
      else                      grant = 2'b01;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= WB_SRC_ALU;
    end else if (&req) begin
      rr_ptr <= (rr_ptr == WB_SRC_ALU) ? WB_SRC_LSU : WB_SRC_ALU;
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Arbitrates the register file write port between ALU and LSU and tracks busy destinations.
// Define REG_WB_FORWARD_EN to bypass writeback data to operands and release hazards in the clearing cycle.
module reg_wb_scheduler
  import reg_wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_has_rd,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [ADDR_W-1:0] lsu_wb_rd,
  input  logic [DATA_W-1:0] lsu_wb_data,
  output logic              lsu_wb_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_addr_rd,
  output logic [DATA_W-1:0] rf_data_rd,
  input  logic [DATA_W-1:0] rf_rs1_in,
  input  logic [DATA_W-1:0] rf_rs2_in,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [CNT_W-1:0]  pending_count,
  output logic              sb_error
);

  wb_req_t                alu_req, lsu_req, sel_req;
  logic [WB_NUM_SRC-1:0]  req, grant;
  logic [NUM_REGS-1:0]    busy, busy_eff, busy_nxt, clr_vec, set_vec;
  logic                   hz_rs1, hz_rs2, hz_rd, set_fire;

  assign alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};
  assign req     = {lsu_req.valid, alu_req.valid};

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign alu_wb_ready = grant[0] & ~reset;
  assign lsu_wb_ready = grant[1] & ~reset;
  assign sel_req      = grant[1] ? lsu_req : alu_req;

  // x0 writes are acknowledged but never reach the register file.
  assign rf_write_en = (|grant) & ~reset & (sel_req.rd != '0);
  assign rf_addr_rd  = sel_req.rd;
  assign rf_data_rd  = sel_req.data;

  assign clr_vec = rf_write_en ? (NUM_REGS'(1) << rf_addr_rd) : '0;

`ifdef REG_WB_FORWARD_EN
  assign busy_eff = busy & ~clr_vec;
  assign rs1_data = (rf_write_en && issue_rs1 == rf_addr_rd) ? rf_data_rd : rf_rs1_in;
  assign rs2_data = (rf_write_en && issue_rs2 == rf_addr_rd) ? rf_data_rd : rf_rs2_in;
`else
  assign busy_eff = busy;
  assign rs1_data = rf_rs1_in;
  assign rs2_data = rf_rs2_in;
`endif

  assign hz_rs1      = (issue_rs1 != '0) & busy_eff[issue_rs1];
  assign hz_rs2      = (issue_rs2 != '0) & busy_eff[issue_rs2];
  assign hz_rd       = (issue_rd  != '0) & busy_eff[issue_rd];
  assign issue_ready = ~reset & ~hz_rs1 & ~hz_rs2 & ~(issue_has_rd & hz_rd);

  assign set_fire = issue_valid & issue_ready & issue_has_rd & (issue_rd != '0);
  assign set_vec  = set_fire ? (NUM_REGS'(1) << issue_rd) : '0;

  // Set is applied after clear so a same-cycle set of the same register wins.
  assign busy_nxt = (busy & ~clr_vec) | set_vec;

  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
      sb_error      <= 1'b0;
    end else begin
      busy          <= busy_nxt;
      pending_count <= popcount(busy_nxt);
      sb_error      <= sb_error | (rf_write_en & ~busy[rf_addr_rd]);
    end
  end

  // Writeback requesters must hold their request until it is granted.
  a_alu_hold: assert property (@(posedge clock)
    (!reset && alu_wb_valid && !alu_wb_ready) |=>
      (alu_wb_valid && $stable(alu_wb_rd) && $stable(alu_wb_data)));
  a_lsu_hold: assert property (@(posedge clock)
    (!reset && lsu_wb_valid && !lsu_wb_ready) |=>
      (lsu_wb_valid && $stable(lsu_wb_rd) && $stable(lsu_wb_data)));

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed self-checking bench for reg_wb_scheduler (default or REG_WB_FORWARD_EN build).
module tb_reg_wb_scheduler;
  import reg_wb_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              issue_valid, issue_has_rd, issue_ready;
  logic [ADDR_W-1:0] issue_rs1, issue_rs2, issue_rd;
  logic              alu_wb_valid, alu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic [ADDR_W-1:0] alu_wb_rd, lsu_wb_rd, rf_addr_rd;
  logic [DATA_W-1:0] alu_wb_data, lsu_wb_data, rf_data_rd;
  logic              rf_write_en, sb_error;
  logic [DATA_W-1:0] rf_rs1_in, rf_rs2_in, rs1_data, rs2_data;
  logic [CNT_W-1:0]  pending_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  reg_wb_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_has_rd(issue_has_rd), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .rf_write_en(rf_write_en), .rf_addr_rd(rf_addr_rd), .rf_data_rd(rf_data_rd),
    .rf_rs1_in(rf_rs1_in), .rf_rs2_in(rf_rs2_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .pending_count(pending_count), .sb_error(sb_error)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_has_rd = 0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_wb_valid = 0; lsu_wb_rd = '0; lsu_wb_data = '0;
    rf_rs1_in = 32'h1111; rf_rs2_in = 32'h2222;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); tick();
    reset = 0; #1;
  endtask

  task automatic issue_one(input logic [ADDR_W-1:0] rd);
    issue_valid = 1; issue_has_rd = 1; issue_rd = rd; issue_rs1 = '0; issue_rs2 = '0;
    tick();
    issue_valid = 0; issue_has_rd = 0; issue_rd = '0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    alu_wb_valid = 1; alu_wb_rd = 5'd1; lsu_wb_valid = 1; lsu_wb_rd = 5'd2;
    tick(); tick();
    checks++; if (alu_wb_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %b expected 0", alu_wb_ready); end
    checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %b expected 0", lsu_wb_ready); end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en: got %b expected 0", rf_write_en); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_issue_ready: got %b expected 0", issue_ready); end
    reset = 0; idle(); #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", pending_count); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL rst_sb_error: got %b expected 0", sb_error); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_issue_ready_after: got %b expected 1", issue_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd5; #1;
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t1_issue_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 0; issue_has_rd = 0; issue_rd = '0; issue_rs1 = 5'd5; #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL t1_count_set: got %0d expected 1", pending_count); end
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t1_hazard: got %b expected 0", issue_ready); end
    issue_rs1 = '0;
    alu_wb_valid = 1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD; #1;
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL t1_alu_ready: got %b expected 1", alu_wb_ready); end
    checks++; if (lsu_wb_ready !== 1'b0) begin errors++; $display("FAIL t1_lsu_ready: got %b expected 0", lsu_wb_ready); end
    checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL t1_write_en: got %b expected 1", rf_write_en); end
    checks++; if (rf_addr_rd !== 5'd5) begin errors++; $display("FAIL t1_addr: got %0d expected 5", rf_addr_rd); end
    checks++; if (rf_data_rd !== 32'hDEAD) begin errors++; $display("FAIL t1_data: got %h expected 0000dead", rf_data_rd); end
    tick();
    alu_wb_valid = 0; #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t1_count_clr: got %0d expected 0", pending_count); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t1_sb_error: got %b expected 0", sb_error); end
  endtask

  task automatic test_arbitration();
    do_reset();
    issue_one(5'd3); issue_one(5'd4); issue_one(5'd6); issue_one(5'd8);
    checks++; if (pending_count !== 6'd4) begin errors++; $display("FAIL t2_count4: got %0d expected 4", pending_count); end
    alu_wb_valid = 1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd4; lsu_wb_data = 32'h44; #1;
    checks++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b01) begin errors++; $display("FAIL t2_c1_grant: got %b expected 01", {alu_wb_ready, lsu_wb_ready}); end
    checks++; if (rf_addr_rd !== 5'd4) begin errors++; $display("FAIL t2_c1_addr: got %0d expected 4", rf_addr_rd); end
    tick();
    lsu_wb_rd = 5'd6; lsu_wb_data = 32'h66; #1;
    checks++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b10) begin errors++; $display("FAIL t2_c2_grant: got %b expected 10", {alu_wb_ready, lsu_wb_ready}); end
    checks++; if (rf_data_rd !== 32'h33) begin errors++; $display("FAIL t2_c2_data: got %h expected 00000033", rf_data_rd); end
    tick();
    alu_wb_rd = 5'd8; alu_wb_data = 32'h88; #1;
    checks++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b01) begin errors++; $display("FAIL t2_c3_grant: got %b expected 01", {alu_wb_ready, lsu_wb_ready}); end
    checks++; if (rf_addr_rd !== 5'd6) begin errors++; $display("FAIL t2_c3_addr: got %0d expected 6", rf_addr_rd); end
    tick();
    lsu_wb_valid = 0; #1;
    checks++; if ({alu_wb_ready, lsu_wb_ready} !== 2'b10) begin errors++; $display("FAIL t2_c4_grant: got %b expected 10", {alu_wb_ready, lsu_wb_ready}); end
    tick();
    alu_wb_valid = 0; #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t2_count0: got %0d expected 0", pending_count); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t2_sb_error: got %b expected 0", sb_error); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue_one(5'd7);
    issue_valid = 1; issue_rs1 = 5'd7; issue_rd = 5'd10; issue_has_rd = 1; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t3_stall: got %b expected 0", issue_ready); end
    tick();
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t3_stall2: got %b expected 0", issue_ready); end
    alu_wb_valid = 1; alu_wb_rd = 5'd7; alu_wb_data = 32'hBEEF; #1;
`ifdef REG_WB_FORWARD_EN
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t3_fwd_ready: got %b expected 1", issue_ready); end
    checks++; if (rs1_data !== 32'hBEEF) begin errors++; $display("FAIL t3_fwd_data: got %h expected 0000beef", rs1_data); end
    tick();
    issue_valid = 0; issue_has_rd = 0; alu_wb_valid = 0; #1;
`else
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t3_wb_cycle_ready: got %b expected 0", issue_ready); end
    checks++; if (rs1_data !== 32'h1111) begin errors++; $display("FAIL t3_nofwd_data: got %h expected 00001111", rs1_data); end
    tick();
    alu_wb_valid = 0; #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t3_count_mid: got %0d expected 0", pending_count); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t3_ready_after: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 0; issue_has_rd = 0; #1;
`endif
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL t3_count_end: got %0d expected 1", pending_count); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    issue_one(5'd9);
    issue_valid = 1; issue_has_rd = 1; issue_rd = 5'd9;
    alu_wb_valid = 1; alu_wb_rd = 5'd9; alu_wb_data = 32'h99; #1;
    checks++; if (alu_wb_ready !== 1'b1) begin errors++; $display("FAIL t4_alu_ready: got %b expected 1", alu_wb_ready); end
`ifdef REG_WB_FORWARD_EN
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t4_issue_ready: got %b expected 1", issue_ready); end
    tick();
    idle(); #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL t4_count: got %0d expected 1", pending_count); end
    issue_rs1 = 5'd9; #1;
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t4_still_busy: got %b expected 0", issue_ready); end
`else
    checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL t4_issue_ready: got %b expected 0", issue_ready); end
    tick();
    alu_wb_valid = 0; #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t4_count: got %0d expected 0", pending_count); end
    tick();
    idle(); #1;
    checks++; if (pending_count !== 6'd1) begin errors++; $display("FAIL t4_count_reissue: got %0d expected 1", pending_count); end
`endif
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t4_sb_error: got %b expected 0", sb_error); end
    idle();
  endtask

  task automatic test_x0_and_error();
    do_reset();
    lsu_wb_valid = 1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'h5; #1;
    checks++; if (lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL t5_x0_ready: got %b expected 1", lsu_wb_ready); end
    checks++; if (rf_write_en !== 1'b0) begin errors++; $display("FAIL t5_x0_we: got %b expected 0", rf_write_en); end
    tick();
    lsu_wb_valid = 0; #1;
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t5_x0_err: got %b expected 0", sb_error); end
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t5_x0_count: got %0d expected 0", pending_count); end
    alu_wb_valid = 1; alu_wb_rd = 5'd12; alu_wb_data = 32'hC; #1;
    checks++; if (rf_write_en !== 1'b1) begin errors++; $display("FAIL t5_we12: got %b expected 1", rf_write_en); end
    tick();
    alu_wb_valid = 0; #1;
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL t5_err_set: got %b expected 1", sb_error); end
    tick(); tick();
    checks++; if (sb_error !== 1'b1) begin errors++; $display("FAIL t5_err_sticky: got %b expected 1", sb_error); end
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t5_count: got %0d expected 0", pending_count); end
    do_reset();
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t5_err_cleared: got %b expected 0", sb_error); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    issue_one(5'd1); issue_one(5'd2); issue_one(5'd3);
    checks++; if (pending_count !== 6'd3) begin errors++; $display("FAIL t6_count3: got %0d expected 3", pending_count); end
    reset = 1;
    alu_wb_valid = 1; alu_wb_rd = 5'd1; lsu_wb_valid = 1; lsu_wb_rd = 5'd2; #1;
    checks++; if ({alu_wb_ready, lsu_wb_ready, rf_write_en} !== 3'b000) begin errors++; $display("FAIL t6_rst_readies: got %b expected 000", {alu_wb_ready, lsu_wb_ready, rf_write_en}); end
    tick();
    checks++; if ({alu_wb_ready, lsu_wb_ready, issue_ready} !== 3'b000) begin errors++; $display("FAIL t6_rst_readies2: got %b expected 000", {alu_wb_ready, lsu_wb_ready, issue_ready}); end
    tick();
    reset = 0; idle(); issue_rs1 = 5'd1; issue_rs2 = 5'd3; #1;
    checks++; if (pending_count !== 6'd0) begin errors++; $display("FAIL t6_count0: got %0d expected 0", pending_count); end
    checks++; if (sb_error !== 1'b0) begin errors++; $display("FAIL t6_sb_error: got %b expected 0", sb_error); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL t6_busy_empty: got %b expected 1", issue_ready); end
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_basic();
    test_arbitration();
    test_raw_stall();
    test_same_cycle();
    test_x0_and_error();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
